io_bus_ctrl: RTL and testbench
==============================

// Module: io_bus_ctrl
// PURPOSE
//  CPU-side sequencer for the memory-mapped IO window; sits directly upstream of the port blocks.
//  Decodes a CPU IO request into a device select plus a 2-bit register offset.
//  Generates timed CS/WE/OE strobes (setup, strobe, hold) and returns read data.
//  Completes every request with a one-cycle ready pulse, or an error pulse on a decode miss.
// PARAMETERS
//  DATA_WIDTH     `DATA_WIDTH  data bus width (8 in current builds)
//  ADDR_WIDTH     8            CPU address width
//  BASE_ADDR      8'hF0        first address of the IO window
//  N_DEV          4            number of devices; each owns 4 consecutive registers
//  STROBE_CYCLES  2            cycles WE/OE held asserted; legal range >=1
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             asynchronous, active-low reset
//  req        in   1             CPU request; sampled only in IDLE
//  wr         in   1             1 = write, 0 = read; sampled with req
//  addr       in   ADDR_WIDTH    CPU address; sampled with req
//  wdata      in   DATA_WIDTH    write data; sampled with req
//  rdata      out  DATA_WIDTH    read data; valid while ready=1
//  ready      out  1             one-cycle completion pulse
//  err        out  1             one-cycle decode-miss pulse, coincident with ready
//  dev_cs     out  N_DEV         one-hot device chip select
//  dev_we     out  1             write strobe, common to all devices
//  dev_oe     out  1             output-enable strobe, common to all devices
//  dev_reg    out  2             register offset within the selected device
//  dev_wdata  out  DATA_WIDTH    registered write data to the devices
//  dev_rdata  in   DATA_WIDTH    read data from the devices, shared bus
// BEHAVIOUR
//  - reset low: state=IDLE. rdata, dev_wdata, dev_cs, dev_reg = 0. ready, err, dev_we, dev_oe = 0.
//    Applies immediately, including mid-transaction. No strobe survives reset.
//  - Decode: off = addr - BASE_ADDR, ADDR_WIDTH-bit subtraction.
//    Hit when addr >= BASE_ADDR and off < 4*N_DEV; then dev = off>>2, dev_reg = off[1:0].
//  - FSM: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE, or IDLE -> ERR -> IDLE.
//  - IDLE: on req=1, capture wr, wdata, decode. Hit -> SETUP; miss -> ERR. req=0 -> stay.
//  - SETUP (1 cycle): dev_cs[dev]=1; dev_reg and dev_wdata stable; WE and OE low.
//  - STROBE (STROBE_CYCLES cycles): dev_we=wr, dev_oe=~wr.
//    A down-counter loads STROBE_CYCLES-1 on entry and exits at 0.
//    Read: dev_rdata is captured into rdata on the last STROBE cycle.
//  - HOLD (1 cycle): WE/OE low, dev_cs still asserted. Address and data unchanged.
//  - DONE (1 cycle): dev_cs=0, ready=1, rdata valid. rdata keeps its value until the next read.
//  - ERR (1 cycle): ready=1, err=1, rdata=0, no CS/WE/OE activity.
//  - Latency from req sampled to ready: 3+STROBE_CYCLES cycles on a hit; 1 cycle on a miss.
//  - req is ignored outside IDLE. Back-to-back: req held through DONE starts the next
//    transaction on the cycle after DONE.
//  - WE and OE are never high together. At most one dev_cs bit is high. dev_cs is 0 in IDLE, DONE and ERR.
//  - Write address/data is stable one cycle before WE rises and one cycle after it falls,
//    meeting the devices' latch setup/hold.
// CONFIGURATION
//  IO_BUS_WAIT_EN defined:
//    - adds input dev_wait (1 bit).
//    - While dev_wait=1 in STROBE with the counter at 0, the FSM stays in STROBE; strobes stay asserted.
//    - Read capture moves to the first cycle with counter=0 and dev_wait=0.
//    - dev_wait is ignored in every other state.
//  IO_BUS_WAIT_EN undefined:
//    - no dev_wait port; fixed STROBE_CYCLES timing.
// TESTING
//  - Reset: hold reset=0 mid-STROBE of a write -> next edge all outputs 0, dev_we=0, state IDLE.
//  - Write hit: req=1, wr=1, addr=8'hF5, wdata=8'hA5 -> dev_cs=4'b0010, dev_reg=1, dev_wdata=8'hA5;
//    dev_we high exactly 2 cycles; ready at cycle 5.
//  - Read hit: addr=8'hFC, dev_rdata=8'h3C -> dev_cs=4'b1000, dev_reg=0, dev_oe high 2 cycles;
//    ready with rdata=8'h3C, err=0.
//  - Decode miss: addr=8'hEF, then addr=8'h00 -> next cycle ready=1, err=1, dev_cs/we/oe never asserted.
//  - Back-to-back: req held high for write F0 then read F3 -> second SETUP follows DONE by 1 cycle;
//    no cycle with WE and OE both high.
//  - IO_BUS_WAIT_EN: dev_wait=1 for 3 cycles on a read -> dev_oe high 5 cycles;
//    rdata = dev_rdata sampled after wait drops.

Source files
------------

// File: rtl/io_bus_ctrl.sv
// CPU-side sequencer for the memory-mapped IO window: decodes a request, drives timed CS/WE/OE
// strobes to the port blocks and returns read data. Define IO_BUS_WAIT_EN to add the dev_wait stretch input.
//
// state  | meaning
// IDLE   | waiting for req; decode and capture on req
// SETUP  | chip select, register offset and write data driven, strobes low
// STROBE | WE or OE asserted while the down-counter runs to zero
// HOLD   | strobes low, chip select and address/data still held
// DONE   | chip select released, one-cycle ready pulse
// ERR    | decode miss, one-cycle ready+err pulse, no device activity

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module io_bus_ctrl #(
    parameter int                    DATA_WIDTH    = `DATA_WIDTH,
    parameter int                    ADDR_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(8'hF0),
    parameter int                    N_DEV         = 4,
    parameter int                    STROBE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef IO_BUS_WAIT_EN
    input  logic                  dev_wait,
`endif
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  err,
    output logic [N_DEV-1:0]      dev_cs,
    output logic                  dev_we,
    output logic                  dev_oe,
    output logic [1:0]            dev_reg,
    output logic [DATA_WIDTH-1:0] dev_wdata,
    input  logic [DATA_WIDTH-1:0] dev_rdata
);

    localparam int DEV_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] off;
    logic                  hit;
    logic [DEV_W-1:0]      dev_idx;
    logic [N_DEV-1:0]      cs_dec;
    logic                  wait_hold;

    // Offset wraps modulo 2^ADDR_WIDTH, so the lower bound needs its own compare.
    assign off     = addr - BASE_ADDR;
    assign hit     = (addr >= BASE_ADDR) && (32'(off) < 32'(4 * N_DEV));
    assign dev_idx = off[DEV_W+1:2];
    assign cs_dec  = N_DEV'(1) << dev_idx;

`ifdef IO_BUS_WAIT_EN
    assign wait_hold = dev_wait;
`else
    assign wait_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            dev_cs    <= '0;
            dev_we    <= 1'b0;
            dev_oe    <= 1'b0;
            dev_reg   <= '0;
            dev_wdata <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        wr_q <= wr;
                        if (hit) begin
                            dev_cs    <= cs_dec;
                            dev_reg   <= off[1:0];
                            dev_wdata <= wdata;
                            state     <= S_SETUP;
                        end else begin
                            rdata <= '0;
                            ready <= 1'b1;
                            err   <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end
                S_SETUP: begin
                    dev_we <= wr_q;
                    dev_oe <= ~wr_q;
                    cnt    <= CNT_LOAD;
                    state  <= S_STROBE;
                end
                S_STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!wait_hold) begin
                        // Last strobe cycle: sample the shared read bus before OE drops.
                        dev_we <= 1'b0;
                        dev_oe <= 1'b0;
                        if (!wr_q) begin
                            rdata <= dev_rdata;
                        end
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    dev_cs <= '0;
                    ready  <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    dev_cs <= '0;
                    dev_we <= 1'b0;
                    dev_oe <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: per-cycle strobe observation plus a scoreboard of completion results.
module tb_io_bus_ctrl;

    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       ready;
    logic       err;
    logic [3:0] dev_cs;
    logic       dev_we;
    logic       dev_oe;
    logic [1:0] dev_reg;
    logic [7:0] dev_wdata;
    logic [7:0] dev_rdata = '0;
    logic       dev_wait = 1'b0;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_rdata = '0;
    int         total = 0;
    int         bad = 0;

    io_bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
`ifdef IO_BUS_WAIT_EN
        .dev_wait  (dev_wait),
`endif
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .err       (err),
        .dev_cs    (dev_cs),
        .dev_we    (dev_we),
        .dev_oe    (dev_oe),
        .dev_reg   (dev_reg),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {rdata, 7'b0, ready, 7'b0, err, 4'b0, dev_cs},
              32'h0);
        check({tag, "_strb"}, {28'b0, dev_we, dev_oe, dev_reg}, 32'h0);
        check({tag, "_wdat"}, {24'b0, dev_wdata}, 32'h0);
    endtask

    // One transaction observed cycle by cycle; cyc=1 is the cycle after req is first sampled
    // (or, when chained after a previous DONE, the intervening IDLE cycle).
    task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] rv, input logic hit, input logic [3:0] ecs,
                           input logic [1:0] ereg, input bit keep, input bit chained,
                           input bit wmode);
        int   we_cnt = 0, oe_cnt = 0, cs_cnt = 0, first_cs = 0, ready_cyc = 0;
        int   extra = wmode ? 3 : 0;
        int   ch = chained ? 1 : 0;
        exp_t e, got;
        if (!chained) @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = wd;
        dev_rdata = wmode ? 8'h11 : rv;
        e.err   = ~hit;
        e.rdata = !hit ? 8'h00 : (w ? model_rdata : rv);
        model_rdata = e.rdata;
        sb.push_back(e);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            check("we_oe_excl", {31'b0, dev_we & dev_oe}, 32'h0);
            check("cs_onehot0", {31'b0, $onehot0(dev_cs)}, 32'h1);
            if (dev_we) we_cnt++;
            if (dev_oe) oe_cnt++;
            if (dev_cs != 4'b0) begin
                cs_cnt++;
                if (first_cs == 0) begin
                    first_cs = cyc;
                    check("setup_cs", {28'b0, dev_cs}, {28'b0, ecs});
                    check("setup_reg", {30'b0, dev_reg}, {30'b0, ereg});
                    check("setup_strb", {30'b0, dev_we, dev_oe}, 32'h0);
                    if (w) check("setup_wdata", {24'b0, dev_wdata}, {24'b0, wd});
                end
            end
            if (!keep && cyc >= 1 + ch) req = 1'b0;
            if (wmode && cyc == 3) dev_wait = 1'b1;
            if (wmode && cyc == 6) begin
                dev_wait  = 1'b0;
                dev_rdata = rv;
            end
            if (ready) begin
                ready_cyc = cyc;
                check("done_cs", {28'b0, dev_cs}, 32'h0);
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'h0, 32'h1);
                end else begin
                    got = sb.pop_front();
                    check("rdata", {24'b0, rdata}, {24'b0, got.rdata});
                    check("err", {31'b0, err}, {31'b0, got.err});
                end
                break;
            end
        end
        if (ready_cyc == 0) check("ready_seen", 32'h0, 32'h1);
        check("latency", ready_cyc, hit ? 3 + SC + extra + ch : 1 + ch);
        check("we_cycles", we_cnt, (hit && w) ? SC : 0);
        check("oe_cycles", oe_cnt, (hit && !w) ? SC + extra : 0);
        check("cs_cycles", cs_cnt, hit ? SC + 2 + extra : 0);
        check("first_cs", first_cs, hit ? 1 + ch : 0);
        if (!keep) begin
            @(negedge clk);
            check("ready_pulse", {30'b0, ready, err}, 32'h0);
        end
    endtask

    initial begin
        #12;
        check_all_zero("rst_init");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        run_txn(1'b1, 8'hF5, 8'hA5, 8'h00, 1'b1, 4'b0010, 2'd1, 0, 0, 0);
        check("wr_wdata_held", {24'b0, dev_wdata}, 32'hA5);
        run_txn(1'b0, 8'hFC, 8'h00, 8'h3C, 1'b1, 4'b1000, 2'd0, 0, 0, 0);
        check("rdata_kept", {24'b0, rdata}, 32'h3C);
        run_txn(1'b1, 8'hF6, 8'h99, 8'h00, 1'b1, 4'b0010, 2'd2, 0, 0, 0);
        check("rdata_after_wr", {24'b0, rdata}, 32'h3C);
        run_txn(1'b0, 8'hEF, 8'h00, 8'h55, 1'b0, 4'b0000, 2'd0, 0, 0, 0);
        run_txn(1'b1, 8'h00, 8'h12, 8'h55, 1'b0, 4'b0000, 2'd0, 0, 0, 0);
        run_txn(1'b0, 8'hFF, 8'h00, 8'h5A, 1'b1, 4'b1000, 2'd3, 0, 0, 0);

        // Back-to-back with req held through DONE.
        run_txn(1'b1, 8'hF0, 8'h5C, 8'h00, 1'b1, 4'b0001, 2'd0, 1, 0, 0);
        run_txn(1'b0, 8'hF3, 8'h00, 8'h77, 1'b1, 4'b0001, 2'd3, 0, 1, 0);

        // Reset during the STROBE phase of a write.
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 8'hF6; wdata = 8'h5A;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("pre_rst_we", {31'b0, dev_we}, 32'h1);
        reset = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        check_all_zero("rst_edge");
        @(negedge clk);
        reset = 1'b1;
        model_rdata = 8'h00;
        sb.delete();
        @(negedge clk);
        check_all_zero("post_rst_idle");
        run_txn(1'b0, 8'hF4, 8'h00, 8'hE1, 1'b1, 4'b0010, 2'd0, 0, 0, 0);

`ifdef IO_BUS_WAIT_EN
        run_txn(1'b0, 8'hF9, 8'h00, 8'hC3, 1'b1, 4'b0100, 2'd1, 0, 0, 1);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
